// File: rtl/odma_axi_rd_arbiter_pkg.sv
// Shared types and constants for the ODMA AXI read-port arbiter.
package odma_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_ISSUE = ISSUE;

  localparam logic [3:0] M_ARCACHE = 4'b0010;

  // At least one bit of channel tag, even for a degenerate single channel.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/odma_axi_rd_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module odma_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int  c;
    logic found;
    c     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
    any = found;
  end

endmodule

// File: rtl/odma_axi_rd_arbiter.sv
// Shares one AXI4 read port between NUM_CH ODMA requesters: round-robin AR
// issue with the channel index tagged into the upper ARID bits, R routed back by tag.
//
// state  | meaning
// IDLE   | may accept one upstream AR this cycle
// ISSUE  | captured AR presented on m_ar*, waiting for m_arready
module odma_axi_rd_arbiter
  import odma_arb_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int AXI_ID_WIDTH     = 5,
  parameter int AXI_ADDR_WIDTH   = 64,
  parameter int AXI_DATA_WIDTH   = 1024,
  parameter int AXI_ARUSER_WIDTH = 9,
  parameter int AXI_RUSER_WIDTH  = 1,
  parameter int MAX_OUTST        = 8,
  localparam int CH_BITS         = ch_bits(NUM_CH)
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic [NUM_CH-1:0]                    s_arvalid,
  output logic [NUM_CH-1:0]                    s_arready,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]     s_araddr,
  input  logic [NUM_CH*8-1:0]                  s_arlen,
  input  logic [NUM_CH*3-1:0]                  s_arsize,
  input  logic [NUM_CH*2-1:0]                  s_arburst,
  input  logic [NUM_CH*AXI_ID_WIDTH-1:0]       s_arid,
  input  logic [NUM_CH*AXI_ARUSER_WIDTH-1:0]   s_aruser,

  output logic [NUM_CH-1:0]                    s_rvalid,
  input  logic [NUM_CH-1:0]                    s_rready,
  output logic [AXI_DATA_WIDTH-1:0]            s_rdata,
  output logic [AXI_ID_WIDTH-1:0]              s_rid,
  output logic [1:0]                           s_rresp,
  output logic                                 s_rlast,
  output logic [AXI_RUSER_WIDTH-1:0]           s_ruser,

  output logic                                 m_arvalid,
  input  logic                                 m_arready,
  output logic [AXI_ADDR_WIDTH-1:0]            m_araddr,
  output logic [7:0]                           m_arlen,
  output logic [2:0]                           m_arsize,
  output logic [1:0]                           m_arburst,
  output logic [AXI_ARUSER_WIDTH-1:0]          m_aruser,
  output logic [AXI_ID_WIDTH+CH_BITS-1:0]      m_arid,
  output logic [3:0]                           m_arcache,
  output logic [2:0]                           m_arprot,
  output logic [1:0]                           m_arlock,
  output logic [3:0]                           m_arqos,
  output logic [3:0]                           m_arregion,

  input  logic                                 m_rvalid,
  output logic                                 m_rready,
  input  logic [AXI_DATA_WIDTH-1:0]            m_rdata,
  input  logic [AXI_ID_WIDTH+CH_BITS-1:0]      m_rid,
  input  logic [1:0]                           m_rresp,
  input  logic                                 m_rlast,
  input  logic [AXI_RUSER_WIDTH-1:0]           m_ruser,

  output logic                                 busy,
  output logic                                 rid_err
);

  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int IDW  = AXI_ID_WIDTH;
  localparam int UW   = AXI_ARUSER_WIDTH;
  localparam int MIDW = AXI_ID_WIDTH + CH_BITS;
  localparam int CW   = $clog2(MAX_OUTST + 1);

  logic [0:0]          state_q,  state_d;
  logic [CH_BITS-1:0]  ptr_q,    ptr_d;
  logic [CW-1:0]       outst_q [NUM_CH];
  logic [CW-1:0]       outst_d [NUM_CH];
  logic                rid_err_q, rid_err_d;

  logic [AW-1:0]       araddr_q,  araddr_d;
  logic [7:0]          arlen_q,   arlen_d;
  logic [2:0]          arsize_q,  arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [UW-1:0]       aruser_q,  aruser_d;
  logic [MIDW-1:0]     arid_q,    arid_d;

  logic [NUM_CH-1:0]   eligible, gnt, inc, dec, r_hit;
  logic [CH_BITS-1:0]  win, r_ch;
  logic                any_req, accept, r_tag_ok, any_outst;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++)
      eligible[i] = s_arvalid[i] && (outst_q[i] < CW'(MAX_OUTST));
  end

  odma_rr_arbiter #(
    .N  (NUM_CH),
    .IW (CH_BITS)
  ) u_rr (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win),
    .any (any_req)
  );

  // Held off during reset so nothing upstream sees a handshake that is then lost.
  assign accept    = (state_q == ST_IDLE) && !rst && any_req;
  assign s_arready = accept ? gnt : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    aruser_d  = aruser_q;
    arid_d    = arid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ISSUE;
          ptr_d     = (int'(win) == NUM_CH - 1) ? '0 : CH_BITS'(int'(win) + 1);
          araddr_d  = s_araddr[int'(win)*AW +: AW];
          arlen_d   = s_arlen[int'(win)*8 +: 8];
          arsize_d  = s_arsize[int'(win)*3 +: 3];
          arburst_d = s_arburst[int'(win)*2 +: 2];
          aruser_d  = s_aruser[int'(win)*UW +: UW];
          arid_d    = {win, s_arid[int'(win)*IDW +: IDW]};
        end
      end
      ST_ISSUE: begin
        if (m_arready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign r_ch = m_rid[MIDW-1 -: CH_BITS];

  always_comb begin
    r_hit = '0;
    for (int i = 0; i < NUM_CH; i++)
      r_hit[i] = (r_ch == CH_BITS'(i));
  end

  // Unknown tags are sunk so the downstream port can never stall on them.
  assign r_tag_ok = |r_hit;
  assign m_rready = r_tag_ok ? |(r_hit & s_rready) : 1'b1;
  assign s_rvalid = m_rvalid ? r_hit : '0;
  assign s_rdata  = m_rdata;
  assign s_rid    = m_rid[IDW-1:0];
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign s_ruser  = m_ruser;

  assign rid_err_d = rid_err_q | (m_rvalid & ~r_tag_ok);

  always_comb begin
    any_outst = 1'b0;
    inc       = '0;
    dec       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i] = accept & gnt[i];
      dec[i] = r_hit[i] & m_rvalid & m_rready & m_rlast & (outst_q[i] != '0);
      if (inc[i] && !dec[i])
        outst_d[i] = outst_q[i] + 1'b1;
      else if (dec[i] && !inc[i])
        outst_d[i] = outst_q[i] - 1'b1;
      else
        outst_d[i] = outst_q[i];
      any_outst = any_outst | (outst_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rid_err_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      aruser_q  <= '0;
      arid_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) outst_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rid_err_q <= rid_err_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      aruser_q  <= aruser_d;
      arid_q    <= arid_d;
      for (int i = 0; i < NUM_CH; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign m_arvalid  = (state_q == ST_ISSUE);
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = arsize_q;
  assign m_arburst  = arburst_q;
  assign m_aruser   = aruser_q;
  assign m_arid     = arid_q;
  assign m_arcache  = M_ARCACHE;
  assign m_arprot   = 3'b000;
  assign m_arlock   = 2'b00;
  assign m_arqos    = 4'b0000;
  assign m_arregion = 4'b0000;

  assign busy    = (state_q == ST_ISSUE) | any_outst;
  assign rid_err = rid_err_q;

endmodule

// File: tb/tb_odma_axi_rd_arbiter.sv
// Directed bench: R-routing vector table plus hand-written AR/R sequences,
// with a 3-channel instance for invalid-tag handling.
module tb_odma_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 4-channel instance
  logic [3:0]   s_arvalid, s_arready;
  logic [127:0] s_araddr;
  logic [31:0]  s_arlen;
  logic [11:0]  s_arsize;
  logic [7:0]   s_arburst;
  logic [19:0]  s_arid;
  logic [35:0]  s_aruser;
  logic [3:0]   s_rvalid, s_rready;
  logic [63:0]  s_rdata;
  logic [4:0]   s_rid;
  logic [1:0]   s_rresp;
  logic         s_rlast;
  logic [0:0]   s_ruser;
  logic         m_arvalid, m_arready;
  logic [31:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic [8:0]   m_aruser;
  logic [6:0]   m_arid;
  logic [3:0]   m_arcache, m_arqos, m_arregion;
  logic [2:0]   m_arprot;
  logic [1:0]   m_arlock;
  logic         m_rvalid, m_rready;
  logic [63:0]  m_rdata;
  logic [6:0]   m_rid;
  logic [1:0]   m_rresp;
  logic         m_rlast;
  logic [0:0]   m_ruser;
  logic         busy, rid_err;

  odma_axi_rd_arbiter #(
    .NUM_CH(4), .AXI_ID_WIDTH(5), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
    .AXI_ARUSER_WIDTH(9), .AXI_RUSER_WIDTH(1), .MAX_OUTST(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid), .s_aruser(s_aruser),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_aruser(m_aruser), .m_arid(m_arid),
    .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arlock(m_arlock), .m_arqos(m_arqos),
    .m_arregion(m_arregion),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser),
    .busy(busy), .rid_err(rid_err)
  );

  // 3-channel instance: tag value 3 is invalid
  logic [2:0]   t_s_arvalid, t_s_arready;
  logic [95:0]  t_s_araddr;
  logic [23:0]  t_s_arlen;
  logic [8:0]   t_s_arsize;
  logic [5:0]   t_s_arburst;
  logic [14:0]  t_s_arid;
  logic [26:0]  t_s_aruser;
  logic [2:0]   t_s_rvalid, t_s_rready;
  logic [63:0]  t_s_rdata;
  logic [4:0]   t_s_rid;
  logic [1:0]   t_s_rresp;
  logic         t_s_rlast;
  logic [0:0]   t_s_ruser;
  logic         t_m_arvalid, t_m_arready;
  logic [31:0]  t_m_araddr;
  logic [7:0]   t_m_arlen;
  logic [2:0]   t_m_arsize;
  logic [1:0]   t_m_arburst;
  logic [8:0]   t_m_aruser;
  logic [6:0]   t_m_arid;
  logic [3:0]   t_m_arcache, t_m_arqos, t_m_arregion;
  logic [2:0]   t_m_arprot;
  logic [1:0]   t_m_arlock;
  logic         t_m_rvalid, t_m_rready;
  logic [63:0]  t_m_rdata;
  logic [6:0]   t_m_rid;
  logic [1:0]   t_m_rresp;
  logic         t_m_rlast;
  logic [0:0]   t_m_ruser;
  logic         t_busy, t_rid_err;

  odma_axi_rd_arbiter #(
    .NUM_CH(3), .AXI_ID_WIDTH(5), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
    .AXI_ARUSER_WIDTH(9), .AXI_RUSER_WIDTH(1), .MAX_OUTST(2)
  ) dut3 (
    .clk(clk), .rst(rst),
    .s_arvalid(t_s_arvalid), .s_arready(t_s_arready), .s_araddr(t_s_araddr), .s_arlen(t_s_arlen),
    .s_arsize(t_s_arsize), .s_arburst(t_s_arburst), .s_arid(t_s_arid), .s_aruser(t_s_aruser),
    .s_rvalid(t_s_rvalid), .s_rready(t_s_rready), .s_rdata(t_s_rdata), .s_rid(t_s_rid),
    .s_rresp(t_s_rresp), .s_rlast(t_s_rlast), .s_ruser(t_s_ruser),
    .m_arvalid(t_m_arvalid), .m_arready(t_m_arready), .m_araddr(t_m_araddr), .m_arlen(t_m_arlen),
    .m_arsize(t_m_arsize), .m_arburst(t_m_arburst), .m_aruser(t_m_aruser), .m_arid(t_m_arid),
    .m_arcache(t_m_arcache), .m_arprot(t_m_arprot), .m_arlock(t_m_arlock), .m_arqos(t_m_arqos),
    .m_arregion(t_m_arregion),
    .m_rvalid(t_m_rvalid), .m_rready(t_m_rready), .m_rdata(t_m_rdata), .m_rid(t_m_rid),
    .m_rresp(t_m_rresp), .m_rlast(t_m_rlast), .m_ruser(t_m_ruser),
    .busy(t_busy), .rid_err(t_rid_err)
  );

  typedef struct {
    logic       rvalid;
    logic [6:0] rid;
    logic       rlast;
    logic [3:0] rready;
    logic [1:0] rresp;
    logic [3:0] e_svalid;
    logic       e_mready;
    logic [4:0] e_rid;
  } rvec_t;

  rvec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arid = '0; s_aruser = '0; s_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0; m_rresp = '0;
    m_rlast = 1'b0; m_ruser = '0;
    t_s_arvalid = '0; t_s_araddr = '0; t_s_arlen = '0; t_s_arsize = '0; t_s_arburst = '0;
    t_s_arid = '0; t_s_aruser = '0; t_s_rready = '0;
    t_m_arready = 1'b0; t_m_rvalid = 1'b0; t_m_rdata = '0; t_m_rid = '0; t_m_rresp = '0;
    t_m_rlast = 1'b0; t_m_ruser = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [3:0] e4;
    logic [6:0] e7;
    int g;

    tbl[0] = '{1'b1, 7'h03, 1'b0, 4'b0001, 2'b00, 4'b0001, 1'b1, 5'd3};
    tbl[1] = '{1'b1, 7'h27, 1'b0, 4'b1101, 2'b10, 4'b0010, 1'b0, 5'd7};
    tbl[2] = '{1'b1, 7'h7F, 1'b1, 4'b1000, 2'b01, 4'b1000, 1'b1, 5'd31};
    tbl[3] = '{1'b0, 7'h40, 1'b0, 4'b0100, 2'b00, 4'b0000, 1'b1, 5'd0};
    tbl[4] = '{1'b1, 7'h49, 1'b1, 4'b1011, 2'b11, 4'b0100, 1'b0, 5'd9};
    tbl[5] = '{1'b0, 7'h24, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 5'd4};
    tbl[6] = '{1'b1, 7'h00, 1'b1, 4'b1110, 2'b10, 4'b0001, 1'b0, 5'd0};
    tbl[7] = '{1'b1, 7'h72, 1'b0, 4'b0111, 2'b00, 4'b1000, 1'b0, 5'd18};

    // Reset state, with requests already asserted
    rst = 1'b1;
    clear_inputs();
    s_arvalid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {m_arvalid, busy, rid_err, s_arready}, {1'b0, 1'b0, 1'b0, 4'b0000});
    chk("arcache", {m_arcache, m_arprot, m_arlock, m_arqos, m_arregion}, {4'b0010, 3'b0, 2'b0, 4'b0, 4'b0});
    rst = 1'b0;
    s_arvalid = '0;

    // R routing table; counters are all zero so rlast beats must not disturb them
    for (int i = 0; i < 8; i++) begin
      tick();
      m_rvalid = tbl[i].rvalid;
      m_rid    = tbl[i].rid;
      m_rlast  = tbl[i].rlast;
      s_rready = tbl[i].rready;
      m_rresp  = tbl[i].rresp;
      #1;
      chk("r_table", {s_rvalid, m_rready, s_rid, s_rresp, s_rlast},
          {tbl[i].e_svalid, tbl[i].e_mready, tbl[i].e_rid, tbl[i].rresp, tbl[i].rlast});
    end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("r_table_idle", {busy, rid_err}, 2'b00);

    // Single request on ch2, four-beat burst
    do_reset();
    s_arvalid = 4'b0100;
    s_arid[2*5 +: 5]    = 5'd5;
    s_arlen[2*8 +: 8]   = 8'd3;
    s_araddr[2*32 +: 32] = 32'h0000_1000;
    #1 chk("a_arready", s_arready, 4'b0100);
    tick();
    s_arvalid = '0;
    chk("a_ar", {m_arvalid, m_arid, m_arlen, m_araddr, busy}, {1'b1, 7'h45, 8'd3, 32'h1000, 1'b1});
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("a_idle", {m_arvalid, busy}, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rid = 7'h45; m_rlast = (b == 3); s_rready = 4'hF;
      m_rdata = 64'hD0 + 64'(b);
      #1;
      chk("a_rbeat", {s_rvalid, m_rready, s_rid, s_rlast, busy},
          {4'b0100, 1'b1, 5'd5, (b == 3), 1'b1});
      chk("a_rdata", s_rdata, 64'hD0 + 64'(b));
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("a_busy_done", busy, 1'b0);

    // All channels requesting: grants 0,1,2,3,0; first AR stalled 5 cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_arid[i*5 +: 5]  = 5'(i + 1);
      s_arlen[i*8 +: 8] = 8'h10 + 8'(i);
    end
    s_arvalid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      g  = k % 4;
      e4 = 4'b0001 << g;
      e7 = 7'((g << 5) | (g + 1));
      #1 chk("b_grant", s_arready, e4);
      tick();
      chk("b_issue", {m_arvalid, s_arready, m_arid}, {1'b1, 4'b0000, e7});
      if (k == 0) begin
        repeat (5) begin
          tick();
          chk("b_hold", {m_arvalid, m_arid, m_arlen, s_arready}, {1'b1, 7'h01, 8'h10, 4'b0000});
        end
      end
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
    end
    s_arvalid = '0;

    // Outstanding cap on ch0
    do_reset();
    s_arvalid = 4'b0001;
    m_arready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1 chk("c_acc", s_arready, 4'b0001);
      tick();
      tick();
    end
    s_arvalid = 4'b0011;
    #1 chk("c_full", s_arready, 4'b0010);
    tick();
    tick();
    s_arvalid = 4'b0001;
    #1 chk("c_blocked", s_arready, 4'b0000);
    m_rvalid = 1'b1; m_rid = 7'h00; m_rlast = 1'b1; s_rready = 4'b0001;
    #1 chk("c_same_cycle", {s_arready, s_rvalid, m_rready}, {4'b0000, 4'b0001, 1'b1});
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("c_reopen", s_arready, 4'b0001);
    s_arvalid = '0;
    m_arready = 1'b0;

    // Accept and rlast on the same channel in the same cycle
    do_reset();
    s_arvalid = 4'b0010;
    m_arready = 1'b1;
    #1 chk("d_acc1", s_arready, 4'b0010);
    tick();
    s_arvalid = '0;
    tick();
    s_arvalid = 4'b0010;
    m_rvalid = 1'b1; m_rid = 7'h20; m_rlast = 1'b1; s_rready = 4'b0010;
    #1 chk("d_both", {s_arready, m_rready, s_rvalid}, {4'b0010, 1'b1, 4'b0010});
    tick();
    s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
    tick();
    chk("d_busy_held", {m_arvalid, busy}, 2'b01);
    m_rvalid = 1'b1; m_rlast = 1'b1;
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("d_busy_clear", busy, 1'b0);
    m_arready = 1'b0;

    // 3-channel instance: valid tag forwarded, invalid tag sunk and flagged
    do_reset();
    chk("e_err0", t_rid_err, 1'b0);
    t_m_rvalid = 1'b1; t_m_rid = 7'h42; t_s_rready = 3'b100;
    #1 chk("e_valid_tag", {t_m_rready, t_s_rvalid, t_s_rid}, {1'b1, 3'b100, 5'd2});
    tick();
    chk("e_no_err", t_rid_err, 1'b0);
    t_m_rid = 7'h61; t_s_rready = 3'b000;
    #1 chk("e_drop", {t_m_rready, t_s_rvalid}, {1'b1, 3'b000});
    tick();
    t_m_rvalid = 1'b0;
    #1 chk("e_err", t_rid_err, 1'b1);
    tick();
    tick();
    chk("e_sticky", {t_rid_err, t_busy}, 2'b10);

    // Reset while an AR is being issued
    do_reset();
    s_arvalid = 4'b1000;
    tick();
    s_arvalid = '0;
    #1 chk("f_issue", {m_arvalid, busy, m_arid}, {1'b1, 1'b1, 7'h60});
    rst = 1'b1;
    #1 chk("f_rst", {m_arvalid, busy, s_arready, t_rid_err}, {1'b0, 1'b0, 4'b0000, 1'b0});
    tick();
    rst = 1'b0;
    m_rvalid = 1'b1; m_rid = 7'h60; m_rlast = 1'b1; s_rready = 4'b1000;
    #1 chk("f_fwd", {s_rvalid, m_rready}, {4'b1000, 1'b1});
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1 chk("f_cnt0", {busy, rid_err, m_arvalid}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
